// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU-drive and result handshake bundle for alu_cmd_sequencer
interface alu_cmd_sequencer_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH + 1);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic [2:0]    cmd_f;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_f;
  logic [7:0]    alu_r;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic [2:0]    res_op;
  logic          res_err;
  logic [CW-1:0] count;
  logic          busy;
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_f, alu_r, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_f, res_valid, res_data, res_op, res_err, count, busy
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_f, alu_r, res_ready,
    output cmd_ready, alu_a, alu_b, alu_f, res_valid, res_data, res_op, res_err, count, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issue to a combinational ALU with in-order result capture
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  alu_cmd_sequencer_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;
  state_t state, state_n;
  logic [10:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [10:0] op;
  logic push, pop, capture, done;
  logic res_valid, res_err;
  logic [7:0] res_data;
  logic [2:0] res_op;
  assign push = io.cmd_valid && io.cmd_ready;
  assign io.cmd_ready = cnt != CW'(DEPTH);
  assign io.count = cnt;
  assign io.busy = state != IDLE || cnt != '0;
  assign {io.alu_f, io.alu_b, io.alu_a} = op;
  assign io.res_valid = res_valid;
  assign io.res_data = res_data;
  assign io.res_op = res_op;
  assign io.res_err = res_err;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    capture = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        pop = cnt != '0;
        state_n = pop ? EXEC : IDLE;
      end
      EXEC: begin
        capture = 1'b1;
        state_n = RESULT;
      end
      RESULT: begin
        done = io.res_ready;
        pop = io.res_ready && cnt != '0;
        state_n = !io.res_ready ? RESULT : pop ? EXEC : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // Storage has no reset; occupancy and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {io.cmd_f, io.cmd_b, io.cmd_a};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      op <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_op <= '0;
      res_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        op <= mem[rd_ptr];
      end
      if (capture) begin
        res_valid <= 1'b1;
        res_err <= &op[10:9];
        res_data <= &op[10:9] ? '0 : io.alu_r;
        res_op <= op[10:8];
      end else if (done) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed vectors plus an in-order scoreboard checking every valid result
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [7:0] data;
    logic err;
    logic [2:0] op;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_res = 0;
  int last_res = -1;
  int stream_start = 0;
  bit stream = 1'b0;
  exp_t exp_q[$];
  alu_cmd_sequencer_if #(.DEPTH(DEPTH)) io ();
  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic exp_t expect_of(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    int r;
    exp_t e;
    case (f[2:1])
      2'b00: r = int'(a) + (f[0] ? 1 : int'(b));
      2'b01: r = int'(a) - (f[0] ? 1 : int'(b));
      2'b10: r = int'(a) * int'(b);
      default: r = 0;
    endcase
    e.data = 8'(r);
    e.err = f[2:1] == 2'b11;
    e.op = f;
    return e;
  endfunction
  // Stand-in ALU; drives junk on illegal opcodes so the sequencer's zeroing is observable.
  always_comb io.alu_r = io.alu_f[2:1] == 2'b11 ? 8'hAA : expect_of(io.alu_a, io.alu_b, io.alu_f).data;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (io.res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result actual=%0h required=none", io.res_data);
        end else begin
          chk("sb_res_data", 32'(io.res_data), 32'(exp_q[0].data));
          chk("sb_res_err", 32'(io.res_err), 32'(exp_q[0].err));
          chk("sb_res_op", 32'(io.res_op), 32'(exp_q[0].op));
        end
        if (io.res_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          n_res++;
          if (stream && last_res > stream_start) chk("stream_gap", 32'(cyc - last_res), 32'd2);
          last_res = cyc;
        end
      end
      if (io.cmd_valid && io.cmd_ready) exp_q.push_back(expect_of(io.cmd_a, io.cmd_b, io.cmd_f));
    end
  end
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    bit ok = 1'b0;
    io.cmd_a = a;
    io.cmd_b = b;
    io.cmd_f = f;
    io.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = io.cmd_ready;
      @(posedge clk);
      #1;
    end
    io.cmd_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask
  task automatic take(input string name, input logic [7:0] d, input logic e, input logic [2:0] f);
    bit ok = 1'b0;
    io.res_ready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (io.res_valid) begin
        ok = 1'b1;
        chk({name, "_data"}, 32'(io.res_data), 32'(d));
        chk({name, "_err"}, 32'(io.res_err), 32'(e));
        chk({name, "_op"}, 32'(io.res_op), 32'(f));
      end
      @(posedge clk);
      #1;
    end
    io.res_ready = 1'b0;
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask
  task automatic drain(input string name);
    bit ok = 1'b0;
    io.res_ready = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = exp_q.size() == 0 && !io.res_valid && !io.busy;
    end
    @(posedge clk);
    #1;
    chk({name, "_drained"}, 32'(ok), 32'd1);
  endtask
  initial begin
    int n0;
    int accepted;
    io.cmd_valid = 1'b0;
    io.cmd_a = '0;
    io.cmd_b = '0;
    io.cmd_f = '0;
    io.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(io.cmd_ready), 32'd1);
    chk("rst_count", 32'(io.count), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_res_valid", 32'(io.res_valid), 32'd0);
    chk("rst_res", {20'd0, io.res_data, io.res_op, io.res_err}, 32'd0);
    chk("rst_alu", {21'd0, io.alu_f, io.alu_b, io.alu_a}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Latency: accept at T0, pop at T1, result valid from T2.
    io.cmd_a = 4'd9;
    io.cmd_b = 4'd6;
    io.cmd_f = 3'b000;
    io.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
    @(negedge clk);
    chk("lat_t0_count", 32'(io.count), 32'd1);
    chk("lat_t0_valid", 32'(io.res_valid), 32'd0);
    @(negedge clk);
    chk("lat_t1_valid", 32'(io.res_valid), 32'd0);
    chk("lat_t1_count", 32'(io.count), 32'd0);
    chk("lat_t1_alu", {21'd0, io.alu_f, io.alu_b, io.alu_a}, {21'd0, 3'b000, 4'd6, 4'd9});
    chk("lat_t1_busy", 32'(io.busy), 32'd1);
    @(negedge clk);
    chk("lat_t2_valid", 32'(io.res_valid), 32'd1);
    @(posedge clk);
    #1;
    take("add_9_6", 8'h0F, 1'b0, 3'b000);
    send(4'd15, 4'd0, 3'b001);
    take("inc_15", 8'h10, 1'b0, 3'b001);
    send(4'd3, 4'd5, 3'b010);
    take("sub_3_5", 8'hFE, 1'b0, 3'b010);
    send(4'd0, 4'd0, 3'b011);
    take("dec_0", 8'hFF, 1'b0, 3'b011);
    send(4'd15, 4'd15, 3'b100);
    take("mul_15_15", 8'hE1, 1'b0, 3'b100);
    send(4'd1, 4'd2, 3'b000);
    send(4'd7, 4'd3, 3'b110);
    send(4'd4, 4'd4, 3'b100);
    take("ill_pre", 8'h03, 1'b0, 3'b000);
    take("ill_mid", 8'h00, 1'b1, 3'b110);
    take("ill_post", 8'h10, 1'b0, 3'b100);
    drain("ill");
    chk("idle_busy", 32'(io.busy), 32'd0);
    // Backpressure: FIFO plus operand path hold DEPTH+1 commands.
    io.res_ready = 1'b0;
    accepted = 0;
    n0 = n_res;
    for (int i = 0; i < 8; i++) begin
      io.cmd_a = 4'(i + 3);
      io.cmd_b = 4'(7 - i);
      io.cmd_f = 3'(i % 6);
      io.cmd_valid = 1'b1;
      @(negedge clk);
      if (io.cmd_ready) accepted++;
      @(posedge clk);
      #1;
    end
    io.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(accepted), 32'd5);
    chk("bp_cmd_ready", 32'(io.cmd_ready), 32'd0);
    chk("bp_count", 32'(io.count), 32'd4);
    @(posedge clk);
    #1;
    io.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_pop", 32'(io.cmd_ready), 32'd0);
    @(negedge clk);
    chk("bp_ready_after_pop", 32'(io.cmd_ready), 32'd1);
    chk("bp_count_after_pop", 32'(io.count), 32'd3);
    @(posedge clk);
    #1;
    drain("bp");
    chk("bp_results", 32'(n_res - n0), 32'd5);
    // Streaming with res_ready held high.
    n0 = n_res;
    io.res_ready = 1'b1;
    stream_start = cyc;
    stream = 1'b1;
    for (int i = 0; i < 16; i++) send(4'($urandom), 4'($urandom), {2'($urandom_range(0, 2)), 1'($urandom)});
    drain("stream");
    stream = 1'b0;
    chk("stream_results", 32'(n_res - n0), 32'd16);
    // Simultaneous push and pop at count = DEPTH-1.
    n0 = n_res;
    io.res_ready = 1'b0;
    send(4'd2, 4'd3, 3'b100);
    send(4'd5, 4'd1, 3'b000);
    send(4'd8, 4'd9, 3'b010);
    send(4'd6, 4'd0, 3'b011);
    io.cmd_a = 4'd11;
    io.cmd_b = 4'd2;
    io.cmd_f = 3'b001;
    io.cmd_valid = 1'b1;
    io.res_ready = 1'b1;
    @(negedge clk);
    chk("pp_count_before", 32'(io.count), 32'd3);
    chk("pp_valid_before", 32'(io.res_valid), 32'd1);
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_after", 32'(io.count), 32'd3);
    @(posedge clk);
    #1;
    drain("pp");
    chk("pp_results", 32'(n_res - n0), 32'd5);
    // Asynchronous reset mid-stream with commands queued and one in flight.
    io.res_ready = 1'b0;
    send(4'd1, 4'd1, 3'b000);
    send(4'd2, 4'd2, 3'b000);
    send(4'd3, 4'd3, 3'b000);
    send(4'd4, 4'd4, 3'b000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_res_valid", 32'(io.res_valid), 32'd0);
    chk("arst_count", 32'(io.count), 32'd0);
    chk("arst_cmd_ready", 32'(io.cmd_ready), 32'd1);
    chk("arst_alu", {21'd0, io.alu_f, io.alu_b, io.alu_a}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    io.res_ready = 1'b1;
    n0 = n_res;
    repeat (10) begin
      @(negedge clk);
      chk("arst_no_result", 32'(io.res_valid), 32'd0);
    end
    chk("arst_results", 32'(n_res - n0), 32'd0);
    @(posedge clk);
    #1;
    send(4'd5, 4'd2, 3'b010);
    take("post_rst_sub", 8'h03, 1'b0, 3'b010);
    drain("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
